// File: rtl/tt_um_uart_tx_echo.sv
// Tiny Tapeout UART transmitter tile (8N1, LSB first) with a one-entry holding buffer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module tt_um_uart_tx_echo #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       buf_q;
    logic             buf_full_q;
    logic             ovf_q;
    logic             done_q;
    logic             tx_q;
    logic             busy_q;
`ifdef UART_TX_PARITY_EN
    logic             par_q;
`endif

    logic send_s1_q, send_s2_q, send_s3_q;
    logic clr_s1_q, clr_s2_q;

    logic send_pulse_c;
    logic bit_end_c;
    logic stop_end_c;
    logic ovf_set_c;
    logic unused_ok;

    // Two-flop synchronisers plus an extra stage on the send request for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_s1_q <= 1'b0;
            send_s2_q <= 1'b0;
            send_s3_q <= 1'b0;
            clr_s1_q  <= 1'b0;
            clr_s2_q  <= 1'b0;
        end else begin
            send_s1_q <= ui_in[0];
            send_s2_q <= send_s1_q;
            send_s3_q <= send_s2_q;
            clr_s1_q  <= ui_in[1];
            clr_s2_q  <= clr_s1_q;
        end
    end

    assign send_pulse_c = send_s2_q & ~send_s3_q & ena;
    assign bit_end_c    = (cnt_q == CNT_LAST);
    assign stop_end_c   = (state_q == ST_STOP) && bit_end_c;
    // A request at the final stop cycle is absorbed by the buffer hand-over, so it never overflows.
    assign ovf_set_c    = send_pulse_c && (state_q != ST_IDLE) && buf_full_q && !stop_end_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            cnt_q  <= ((state_q == ST_IDLE) || bit_end_c) ? '0 : cnt_q + CNT_W'(1);
            done_q <= (state_q == ST_STOP) && (cnt_q == CNT_DONE);
            ovf_q  <= ovf_set_c | (ovf_q & ~clr_s2_q);

            if (send_pulse_c && (state_q != ST_IDLE) && !stop_end_c && !buf_full_q) begin
                buf_q      <= uio_in;
                buf_full_q <= 1'b1;
            end

            // tx/busy are loaded with the value belonging to the state being entered.
            case (state_q)
                ST_IDLE: begin
                    if (send_pulse_c) begin
                        shift_q <= uio_in;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^uio_in;
`endif
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_c) begin
                        state_q <= ST_DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end_c) begin
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_c) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_c) begin
                        if (buf_full_q) begin
                            shift_q <= buf_q;
`ifdef UART_TX_PARITY_EN
                            par_q   <= ^buf_q;
`endif
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                            if (send_pulse_c) begin
                                buf_q <= uio_in;
                            end else begin
                                buf_full_q <= 1'b0;
                            end
                        end else if (send_pulse_c) begin
                            shift_q <= uio_in;
`ifdef UART_TX_PARITY_EN
                            par_q   <= ^uio_in;
`endif
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out    = {3'b000, done_q, ovf_q, buf_full_q, busy_q, tx_q};
    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, ui_in[7:2]};

endmodule

// File: tb/tb_tt_um_uart_tx_echo.sv
// Self-checking bench for tt_um_uart_tx_echo: a UART decoder checks frames against a byte scoreboard.
`timescale 1ns/1ps
module tb_tt_um_uart_tx_echo;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    bit         mon_en   = 1'b0;

    always #5 clk = ~clk;

    tt_um_uart_tx_echo #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    // UART decoder: samples mid-bit and compares each frame against the scoreboard.
    initial begin : monitor
        logic       prev;
        logic [7:0] got;
        logic [7:0] want;
        logic       start_bit;
        logic       stop_bit;
`ifdef UART_TX_PARITY_EN
        logic       par_got;
`endif
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && (uo_out[0] == 1'b0)) begin
                repeat (CPB / 2) @(negedge clk);
                start_bit = uo_out[0];
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = uo_out[0];
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                par_got = uo_out[0];
`endif
                repeat (CPB) @(negedge clk);
                stop_bit = uo_out[0];
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL mon_unexpected: got frame %02h, required no frame", got);
                end else begin
                    want = exp_q.pop_front();
                    if ((got !== want) || (start_bit !== 1'b0) || (stop_bit !== 1'b1)) begin
                        failures++;
                        $display("FAIL mon_frame: got %02h start=%b stop=%b, required %02h start=0 stop=1",
                                 got, start_bit, stop_bit, want);
                    end
`ifdef UART_TX_PARITY_EN
                    checks++;
                    if (par_got !== ^want) begin
                        failures++;
                        $display("FAIL mon_parity: got %b, required %b for %02h", par_got, ^want, want);
                    end
`endif
                end
            end
            prev = uo_out[0];
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [7:0] d);
        uio_in   = d;
        ui_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        ui_in[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!uo_out[1]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int bad;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (uo_out !== 8'h01) begin
            failures++;
            $display("FAIL reset_state: got uo_out=%02h, required 01", uo_out);
        end
        checks++;
        if ({uio_out, uio_oe} !== 16'h0000) begin
            failures++;
            $display("FAIL uio_tie: got %02h/%02h, required 00/00", uio_out, uio_oe);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h96);
        send(8'h69);
        checks++;
        if (uo_out[2:0] !== 3'b110) begin
            failures++;
            $display("FAIL reset_pre: got uo_out[2:0]=%b, required 110", uo_out[2:0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ((uo_out[0] !== 1'b1) || (uo_out[4:1] !== 4'b0000)) begin
            failures++;
            $display("FAIL reset_async: got uo_out=%02h, required 01", uo_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (uo_out !== 8'h01) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_discard: got %0d non-idle cycles, required 0", bad);
        end
    endtask

    task automatic test_frame;
        logic [7:0] d;
        logic       e;
        int         nb;
        d = 8'hA5;
        exp_q.push_back(d);
        uio_in   = d;
        ui_in[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (uo_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL lat_k: got tx=%b, required 1", uo_out[0]);
        end
        @(negedge clk);
        checks++;
        if (uo_out[1:0] !== 2'b01) begin
            failures++;
            $display("FAIL lat_k1: got busy,tx=%b, required 01", uo_out[1:0]);
        end
        @(negedge clk);
        ui_in[0] = 1'b0;
        for (int j = 0; j < FRAME; j++) begin
            if (j > 0) @(negedge clk);
            nb = j / CPB;
            if (nb == 0) e = 1'b0;
            else if (nb <= 8) e = d[nb-1];
            else if (PAR && (nb == 9)) e = ^d;
            else e = 1'b1;
            checks++;
            if (uo_out[0] !== e) begin
                failures++;
                $display("FAIL tx_bit: cycle %0d got %b, required %b", j, uo_out[0], e);
            end
            checks++;
            if (uo_out[1] !== 1'b1) begin
                failures++;
                $display("FAIL busy: cycle %0d got %b, required 1", j, uo_out[1]);
            end
            checks++;
            if (uo_out[4] !== (j == FRAME - 1)) begin
                failures++;
                $display("FAIL done: cycle %0d got %b, required %b", j, uo_out[4], (j == FRAME - 1));
            end
        end
        @(negedge clk);
        checks++;
        if (uo_out !== 8'h01) begin
            failures++;
            $display("FAIL frame_end: got uo_out=%02h, required 01", uo_out);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        bit seen;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send(8'h3C);
        repeat (30) @(negedge clk);
        send(8'hC3);
        checks++;
        if (uo_out[2] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_buf_full: got %b, required 1", uo_out[2]);
        end
        seen = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (uo_out[4]) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL b2b_done_timeout: got no done pulse, required one");
        end
        @(negedge clk);
        checks++;
        if (uo_out[2:0] !== 3'b010) begin
            failures++;
            $display("FAIL b2b_gap: got buf,busy,tx=%b, required 010", uo_out[2:0]);
        end
        wait_idle(2 * FRAME, ok);
        checks++;
        if (!ok || (exp_q.size() != 0) || (uo_out[3] !== 1'b0)) begin
            failures++;
            $display("FAIL b2b_end: got idle=%b pending=%0d ovf=%b, required 1 0 0",
                     ok, exp_q.size(), uo_out[3]);
        end
    endtask

    task automatic test_boundary;
        bit ok;
        // Empty buffer: request lands exactly on the final stop cycle.
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h7E);
        uio_in   = 8'h81;
        ui_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        ui_in[0] = 1'b0;
        repeat (FRAME - 3) @(negedge clk);
        uio_in   = 8'h7E;
        ui_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (uo_out[4] !== 1'b1) begin
            failures++;
            $display("FAIL bnd_done: got %b, required 1", uo_out[4]);
        end
        @(negedge clk);
        checks++;
        if (uo_out[3:0] !== 4'b0010) begin
            failures++;
            $display("FAIL bnd_empty: got ovf,buf,busy,tx=%b, required 0010", uo_out[3:0]);
        end
        ui_in[0] = 1'b0;
        wait_idle(2 * FRAME, ok);
        checks++;
        if (!ok || (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL bnd_empty_end: got idle=%b pending=%0d, required 1 0", ok, exp_q.size());
        end
        // Full buffer: buffer hands over and the new byte refills it without overflow.
        exp_q.push_back(8'hC4);
        exp_q.push_back(8'h2B);
        exp_q.push_back(8'hD2);
        uio_in   = 8'hC4;
        ui_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        ui_in[0] = 1'b0;
        repeat (40) @(negedge clk);
        uio_in   = 8'h2B;
        ui_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        ui_in[0] = 1'b0;
        repeat (FRAME - 3 - 44) @(negedge clk);
        uio_in   = 8'hD2;
        ui_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (uo_out[3:0] !== 4'b0110) begin
            failures++;
            $display("FAIL bnd_full: got ovf,buf,busy,tx=%b, required 0110", uo_out[3:0]);
        end
        ui_in[0] = 1'b0;
        wait_idle(3 * FRAME, ok);
        checks++;
        if (!ok || (exp_q.size() != 0) || (uo_out[3:2] !== 2'b00)) begin
            failures++;
            $display("FAIL bnd_full_end: got idle=%b pending=%0d ovf,buf=%b, required 1 0 00",
                     ok, exp_q.size(), uo_out[3:2]);
        end
    endtask

    task automatic test_overflow;
        bit ok;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        checks++;
        if (uo_out[3:2] !== 2'b11) begin
            failures++;
            $display("FAIL ovf_set: got ovf,buf=%b, required 11", uo_out[3:2]);
        end
        wait_idle(3 * FRAME, ok);
        checks++;
        if (!ok || (exp_q.size() != 0) || (uo_out[3] !== 1'b1)) begin
            failures++;
            $display("FAIL ovf_sticky: got idle=%b pending=%0d ovf=%b, required 1 0 1",
                     ok, exp_q.size(), uo_out[3]);
        end
        ui_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (uo_out[3] !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got %b, required 0", uo_out[3]);
        end
        ui_in[1] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ena;
        bit ok;
        int bad;
        ena = 1'b0;
        send(8'hE7);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (uo_out[1:0] !== 2'b01) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL ena_ignore: got %0d busy cycles, required 0", bad);
        end
        ena = 1'b1;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h77);
        send(8'h5A);
        send(8'h77);
        repeat (20) @(negedge clk);
        ena = 1'b0;
        wait_idle(3 * FRAME, ok);
        checks++;
        if (!ok || (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL ena_midframe: got idle=%b pending=%0d, required 1 0", ok, exp_q.size());
        end
        ena = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame_len;
        logic [7:0] vals [2];
        logic [7:0] d;
        logic       samp;
        int         len;
        vals[0] = 8'h07;
        vals[1] = 8'h03;
        for (int v = 0; v < 2; v++) begin
            d = vals[v];
            exp_q.push_back(d);
            uio_in   = d;
            ui_in[0] = 1'b1;
            len  = 0;
            samp = 1'bx;
            for (int i = 0; i < 2 * FRAME + 20; i++) begin
                @(negedge clk);
                if (i == 3) ui_in[0] = 1'b0;
                if (uo_out[1]) begin
                    if (len == 9 * CPB + CPB / 2) samp = uo_out[0];
                    len++;
                end else if (len > 0) begin
                    break;
                end
            end
            checks++;
            if (len != FRAME) begin
                failures++;
                $display("FAIL frame_len: byte %02h got %0d cycles, required %0d", d, len, FRAME);
            end
            checks++;
            if (samp !== (PAR ? ^d : 1'b1)) begin
                failures++;
                $display("FAIL bit9: byte %02h got %b, required %b", d, samp, (PAR ? ^d : 1'b1));
            end
            repeat (3) @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL len_pending: got %0d frames outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        mon_en = 1'b1;
        test_frame;
        test_back_to_back;
        test_boundary;
        test_overflow;
        test_ena;
        test_frame_len;
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
